// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one SRAM-style VRAM port (fixed read latency RD_LAT) between the VGA
// controller's fetch stream and a CPU access port. Video fetches win by
// default. A wait counter forces a CPU slot after MAX_WAIT lost cycles, and a
// one-entry skid absorbs the video fetch that collides with a forced grant.
// Read data returns in issue order and is steered back to its owner by a tag
// that travels down an RD_LAT-deep return pipeline.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_vid_req/addr      video fetch strobe (one fetch per cycle) and address
//   o_vid_valid/data    video return pulse and data (no fixed latency)
//   i_cpu_req/we/addr/wdata  CPU request, held until o_cpu_ack
//   o_cpu_ack/rdata     one-cycle completion pulse, CPU read data
//   o_mem_*             registered VRAM address/write data/we/oe
//   i_mem_rdata         VRAM read data, valid RD_LAT cycles after o_mem_addr
//   o_cpu_starved       sticky: a forced CPU grant has happened since reset
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic          o_vid_valid,
    output logic [DW-1:0] o_vid_data,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_ack,
    output logic [DW-1:0] o_cpu_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_we,
    output logic          o_mem_oe,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_cpu_starved
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic          TAG_VID  = 1'b0;
    localparam logic          TAG_CPU  = 1'b1;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_BUSY = 2'd1,
        C_DONE = 2'd2
    } cpu_state_t;

    cpu_state_t        state_q, state_d;
    logic [CW-1:0]     wait_q;
    logic              skid_full_q;
    logic [AW-1:0]     skid_addr_q;
    logic [RD_LAT-1:0] pipe_valid_q;
    logic [RD_LAT-1:0] pipe_tag_q;

    logic          vid_src;
    logic [AW-1:0] vid_src_addr;
    logic          cpu_pending;
    logic          force_grant;
    logic          issue_vid;
    logic          issue_cpu;
    logic          issue_read;
    logic          tail_valid;
    logic          tail_cpu;

    // -------------------------------------------------------------------------
    // Issue decision
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        vid_src      = skid_full_q | i_vid_req;
        vid_src_addr = skid_full_q ? skid_addr_q : i_vid_addr;
        cpu_pending  = (state_q == C_IDLE) && i_cpu_req;
        // A forced grant waits for an empty skid: with the skid occupied there
        // would be nowhere to park the colliding video fetch.
        force_grant  = cpu_pending && (wait_q == WAIT_MAX) && !skid_full_q;
        issue_vid    = vid_src && !force_grant;
        issue_cpu    = !issue_vid && cpu_pending;
        issue_read   = issue_vid || (issue_cpu && !i_cpu_we);
        tail_valid   = pipe_valid_q[RD_LAT-1];
        tail_cpu     = (pipe_tag_q[RD_LAT-1] == TAG_CPU);
    end

    // -------------------------------------------------------------------------
    // CPU FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            C_IDLE:  if (issue_cpu) state_d = i_cpu_we ? C_DONE : C_BUSY;
            C_BUSY:  if (tail_valid && tail_cpu) state_d = C_DONE;
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    assign o_cpu_ack = (state_q == C_DONE);

    // -------------------------------------------------------------------------
    // Control state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values.
        if (i_reset) begin
            state_q       <= C_IDLE;
            wait_q        <= '0;
            skid_full_q   <= 1'b0;
            pipe_valid_q  <= '0;
            o_vid_valid   <= 1'b0;
            o_vid_data    <= '0;
            o_cpu_rdata   <= '0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_mem_we      <= 1'b0;
            o_mem_oe      <= 1'b0;
            o_cpu_starved <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_mem_we    <= 1'b0;
            o_mem_oe    <= 1'b0;
            o_vid_valid <= 1'b0;

            if (issue_vid) begin
                o_mem_addr <= vid_src_addr;
                o_mem_oe   <= 1'b1;
            end else if (issue_cpu) begin
                o_mem_addr <= i_cpu_addr;
                if (i_cpu_we) begin
                    o_mem_we    <= 1'b1;
                    o_mem_wdata <= i_cpu_wdata;
                end else begin
                    o_mem_oe <= 1'b1;
                end
            end

            // A full skid is always issued this cycle, so it refills only from
            // a back-to-back request; an empty one fills only on a forced grant.
            skid_full_q <= skid_full_q ? i_vid_req : (force_grant && i_vid_req);

            if (issue_cpu) begin
                wait_q <= '0;
            end else if (cpu_pending && (wait_q != WAIT_MAX)) begin
                wait_q <= wait_q + CW'(1);
            end

            if (force_grant) begin
                o_cpu_starved <= 1'b1;
            end

            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
            pipe_valid_q[0] <= issue_read;

            if (tail_valid) begin
                if (tail_cpu) begin
                    o_cpu_rdata <= i_mem_rdata;
                end else begin
                    o_vid_data  <= i_mem_rdata;
                    o_vid_valid <= 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Data-only registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: these carry no reset; they are only consumed when a reset-cleared valid bit qualifies them.
        if (i_vid_req && (skid_full_q || force_grant)) begin
            skid_addr_q <= i_vid_addr;
        end
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
        pipe_tag_q[0] <= issue_vid ? TAG_VID : TAG_CPU;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter. A synchronous VRAM model with RD_LAT=2
// answers reads with a fixed address pattern (0x000100 preloaded with 0xA5)
// and records writes. Expected video and CPU read data are pushed to queues
// when a request is driven and popped by a negedge monitor as returns appear.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW       = 24;
    localparam int DW       = 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 15;

    typedef struct {
        bit            is_read;
        logic [DW-1:0] data;
    } cpu_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_oe;
    logic [DW-1:0] mem_rdata;
    logic          cpu_starved;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_vid_req    (vid_req),
        .i_vid_addr   (vid_addr),
        .o_vid_valid  (vid_valid),
        .o_vid_data   (vid_data),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_ack    (cpu_ack),
        .o_cpu_rdata  (cpu_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_we     (mem_we),
        .o_mem_oe     (mem_oe),
        .i_mem_rdata  (mem_rdata),
        .o_cpu_starved(cpu_starved)
    );

    // ---------------------------------------------------------------- VRAM model
    function automatic logic [DW-1:0] pattern(input logic [15:0] a);
        if (a == 16'h0100) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic [DW-1:0] wr_data  [65536];
    bit            wr_valid [65536];

    // Address registered by the DUT at edge N is read at edge N+1, so data is
    // on i_mem_rdata RD_LAT(=2) edges after the address edge.
    always @(posedge clk) begin
        mem_rdata <= wr_valid[mem_addr[15:0]] ? wr_data[mem_addr[15:0]] : pattern(mem_addr[15:0]);
        if (mem_we) begin
            wr_valid[mem_addr[15:0]] <= 1'b1;
            wr_data[mem_addr[15:0]]  <= mem_wdata;
        end
    end

    // ---------------------------------------------------------------- bookkeeping
    int n_assert  = 0;
    int n_fail    = 0;
    int vid_seen  = 0;
    int ack_seen  = 0;
    int cycle_cnt = 0;
    int cpu_issue_cyc;
    int probe_cyc;
    logic          track = 1'b0;
    logic [AW-1:0] trk_cpu_addr;
    logic [AW-1:0] probe_addr;
    logic [AW-1:0] next_vid_addr;

    logic [DW-1:0] vid_q [$];
    cpu_exp_t      cpu_q [$];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Steps from the current cycle until o_cpu_ack, then drops the request.
    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        do begin
            step();
            sample();
            lat++;
        end while (!cpu_ack && lat < budget);
        if (!cpu_ack) check("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
        step();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (vid_valid) begin
                vid_seen++;
                if (vid_q.size() == 0) check("vid_unexpected", 32'(vid_valid), 32'd0);
                else check("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
            end
            if (cpu_ack) begin
                cpu_exp_t e;
                ack_seen++;
                if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                else begin
                    e = cpu_q.pop_front();
                    if (e.is_read) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                end
            end
            if (track && mem_oe && !mem_we) begin
                if (mem_addr == trk_cpu_addr) cpu_issue_cyc = cycle_cnt;
                else begin
                    if (mem_addr == probe_addr) probe_cyc = cycle_cnt;
                    check("vid_issue_order", 32'(mem_addr), 32'(next_vid_addr));
                    next_vid_addr = next_vid_addr + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int lat;
        int c;
        int base_vid;
        int base_ack;
        bit drop;

        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        trk_cpu_addr = '1; probe_addr = '1; next_vid_addr = '0;
        cpu_issue_cyc = -1; probe_cyc = -1;

        // Reset state
        repeat (3) step();
        sample();
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_ctrl", 32'({mem_we, mem_oe, vid_valid, cpu_ack, cpu_starved}), 32'd0);
        check("reset_data", 32'({vid_data, cpu_rdata, mem_wdata}), 32'd0);
        step();
        rst = 1'b0;

        // Single video read of 0x000100
        vid_req = 1'b1; vid_addr = 24'h000100; vid_q.push_back(8'hA5);
        step();
        vid_req = 1'b0;
        sample();
        check("vid_mem_addr", 32'(mem_addr), 32'h000100);
        check("vid_mem_ctrl", 32'({mem_oe, mem_we}), 32'b10);
        lat = 1;
        while (!vid_valid && lat < 10) begin
            step();
            sample();
            lat++;
        end
        check("vid_latency", 32'(lat), 32'(RD_LAT + 1));
        check("vid_other_outs", 32'({cpu_ack, cpu_starved, mem_oe, mem_we}), 32'd0);

        // CPU write 0x00FFEE <= 0x3C, then a read-back raised right after the ack
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h00FFEE; cpu_wdata = 8'h3C;
        cpu_q.push_back('{1'b0, 8'h00});
        step();
        sample();
        check("wr_mem_ctrl", 32'({mem_we, mem_oe, mem_wdata}), 32'({1'b1, 1'b0, 8'h3C}));
        check("wr_mem_addr", 32'(mem_addr), 32'h00FFEE);
        check("wr_ack", 32'(cpu_ack), 32'd1);
        step();
        cpu_we = 1'b0;
        cpu_q.push_back('{1'b1, 8'h3C});
        sample();
        check("wr_single_cycle", 32'({mem_we, cpu_ack}), 32'd0);
        step();
        sample();
        check("rb_accept", 32'({mem_oe, mem_addr}), 32'({1'b1, 24'h00FFEE}));
        wait_ack(10, lat);
        check("rb_ack_lat", 32'(lat), 32'd2);

        // CPU read of 0x001234, no video traffic, exactly one ack
        step();
        base_ack = ack_seen;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h001234;
        cpu_q.push_back('{1'b1, pattern(16'h1234)});
        wait_ack(10, lat);
        check("rd_ack_lat", 32'(lat), 32'(RD_LAT + 1));
        repeat (5) step();
        sample();
        check("rd_one_ack", 32'(ack_seen - base_ack), 32'd1);

        // Simultaneous video and CPU below MAX_WAIT: CPU waits for the first idle cycle
        step();
        track = 1'b1; trk_cpu_addr = 24'h000050; next_vid_addr = 24'h000040;
        cpu_issue_cyc = -1;
        c = cycle_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000050;
        cpu_q.push_back('{1'b1, pattern(16'h0050)});
        for (int j = 0; j < 3; j++) begin
            vid_req = 1'b1; vid_addr = 24'h000040 + 24'(j);
            vid_q.push_back(pattern(16'h0040 + 16'(j)));
            step();
        end
        vid_req = 1'b0;
        wait_ack(10, lat);
        check("sim_cpu_issue_cycle", 32'(cpu_issue_cyc), 32'(c + 4));
        check("sim_cpu_ack_lat", 32'(lat), 32'(RD_LAT + 1));
        for (int k = 0; k < 10 && vid_q.size() != 0; k++) step();
        check("sim_vid_drained", 32'(vid_q.size()), 32'd0);
        check("sim_vid_issued", 32'(next_vid_addr), 32'h000043);

        // 40 back-to-back video fetches with a waiting CPU read: forced grant
        step();
        trk_cpu_addr = 24'h002000; next_vid_addr = '0; probe_addr = 24'd15;
        cpu_issue_cyc = -1; probe_cyc = -1;
        base_vid = vid_seen; drop = 1'b0;
        c = cycle_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h002000;
        cpu_q.push_back('{1'b1, pattern(16'h2000)});
        for (int j = 0; j < 40; j++) begin
            vid_req = 1'b1; vid_addr = 24'(j);
            vid_q.push_back(pattern(16'(j)));
            if (drop) cpu_req = 1'b0;
            sample();
            if (cpu_ack) drop = 1'b1;
            step();
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int k = 0; k < 20 && (vid_seen - base_vid) < 40; k++) step();
        sample();
        check("stv_vid_count", 32'(vid_seen - base_vid), 32'd40);
        check("stv_vid_issued", 32'(next_vid_addr), 32'd40);
        check("stv_cpu_issue_cycle", 32'(cpu_issue_cyc), 32'(c + MAX_WAIT + 1));
        check("stv_collided_fetch", 32'(probe_cyc), 32'(c + MAX_WAIT + 2));
        check("stv_cpu_acked", 32'(drop), 32'd1);
        check("stv_starved", 32'(cpu_starved), 32'd1);
        track = 1'b0;

        // Reset one cycle after a video and a CPU read issue
        step();
        vid_req = 1'b1; vid_addr = 24'h000010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000030;
        step();
        vid_req = 1'b0;
        step();
        sample();
        check("rstmid_cpu_issued", 32'({mem_oe, mem_addr}), 32'({1'b1, 24'h000030}));
        base_vid = vid_seen; base_ack = ack_seen;
        step();
        rst = 1'b1; cpu_req = 1'b0;
        vid_q.delete(); cpu_q.delete();
        step();
        rst = 1'b0;
        sample();
        check("rstmid_outs", 32'({vid_valid, cpu_ack, mem_oe, mem_we, cpu_starved}), 32'd0);
        repeat (8) step();
        sample();
        check("rstmid_no_valid", 32'(vid_seen - base_vid), 32'd0);
        check("rstmid_no_ack", 32'(ack_seen - base_ack), 32'd0);

        // New CPU read after reset completes normally
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000777;
        cpu_q.push_back('{1'b1, pattern(16'h0777)});
        wait_ack(10, lat);
        check("post_rst_ack_lat", 32'(lat), 32'(RD_LAT + 1));
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
